// File: rtl/iss_inorder_n_if.sv
// Issue-stage bus: the instruction-queue head slots coming in and the
// per-unit output registers with their valid/ready handshake going out.
interface iss_inorder_n_if #(
  parameter int ISSUE_W = 4,
  parameter int N_ALU   = 2,
  parameter int N_MUL   = 1,
  parameter int ROB_W   = 4,
  parameter int DW      = 32,
  parameter int IW      = 64
);
  localparam int NU = N_ALU + N_MUL + 2;
  localparam int CW = $clog2(ISSUE_W + 1);

  // Instruction-queue head (slot 0 oldest)
  logic [ISSUE_W-1:0]       slot_valid_i;
  logic [ISSUE_W-1:0]       slot_ops_ready_i;
  logic [2*ISSUE_W-1:0]     slot_class_i;
  logic [ROB_W*ISSUE_W-1:0] slot_rob_i;
  logic [DW*ISSUE_W-1:0]    slot_a_i;
  logic [DW*ISSUE_W-1:0]    slot_b_i;
  logic [DW*ISSUE_W-1:0]    slot_c_i;
  logic [IW*ISSUE_W-1:0]    slot_inst_i;
  logic                     iq_enable_o;
  logic [CW-1:0]            iq_consumed_o;

  // Functional-unit output registers
  logic [NU-1:0]            u_valid_o;
  logic [NU-1:0]            u_ready_i;
  logic [ROB_W*NU-1:0]      u_rob_o;
  logic [DW*NU-1:0]         u_a_o;
  logic [DW*NU-1:0]         u_b_o;
  logic [DW*NU-1:0]         u_c_o;
  logic [IW*NU-1:0]         u_inst_o;

  // Issue stage side
  modport slave (
    input  slot_valid_i, slot_ops_ready_i, slot_class_i, slot_rob_i,
    input  slot_a_i, slot_b_i, slot_c_i, slot_inst_i, u_ready_i,
    output iq_enable_o, iq_consumed_o,
    output u_valid_o, u_rob_o, u_a_o, u_b_o, u_c_o, u_inst_o
  );

  // Instruction queue / functional units side
  modport master (
    output slot_valid_i, slot_ops_ready_i, slot_class_i, slot_rob_i,
    output slot_a_i, slot_b_i, slot_c_i, slot_inst_i, u_ready_i,
    input  iq_enable_o, iq_consumed_o,
    input  u_valid_o, u_rob_o, u_a_o, u_b_o, u_c_o, u_inst_o
  );
endinterface

// File: rtl/iss_inorder_n.sv
// In-order issue stage: steers the oldest ready IQ entries, strictly in
// order, onto free functional units and holds each issued instruction in a
// per-unit register until the unit accepts it. A branch only issues together
// with its delay slot. flush squashes every unit register.
module iss_inorder_n #(
  parameter int ISSUE_W = 4,
  parameter int N_ALU   = 2,
  parameter int N_MUL   = 1,
  parameter int ROB_W   = 4,
  parameter int DW      = 32,
  parameter int IW      = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush_i,
  iss_inorder_n_if.slave  bus
);
  localparam int NU     = N_ALU + N_MUL + 2;
  localparam int LS_IDX = NU - 2;
  localparam int BR_IDX = NU - 1;
  localparam int UW     = $clog2(NU);
  localparam int SW     = $clog2(ISSUE_W);
  localparam int CW     = $clog2(ISSUE_W + 1);

  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_MUL = 2'd1;
  localparam logic [1:0] CLS_LS  = 2'd2;
  localparam logic [1:0] CLS_BR  = 2'd3;

  // Unit registers
  logic [NU-1:0]       u_valid_q;
  logic [ROB_W*NU-1:0] u_rob_q;
  logic [DW*NU-1:0]    u_a_q;
  logic [DW*NU-1:0]    u_b_q;
  logic [DW*NU-1:0]    u_c_q;
  logic [IW*NU-1:0]    u_inst_q;

  // Selection state
  logic [NU-1:0]      unit_free;
  logic [NU-1:0]      used;
  logic [NU-1:0]      avail;
  logic               stop;
  logic               pend_br;
  logic               found;
  logic               ok;
  logic [UW-1:0]      pick;
  logic [SW-1:0]      br_slot;
  logic [1:0]         cls;
  logic [CW-1:0]      cnt_d;
  logic [ISSUE_W-1:0] slot_iss;
  logic [UW-1:0]      slot_unit [ISSUE_W];

  // Unit load decode
  logic [NU-1:0]      load;
  logic [SW-1:0]      load_src [NU];
  logic               hit;

  // A unit can take a new instruction if empty or its occupant leaves now
  assign unit_free = ~u_valid_q | bus.u_ready_i;

  // Walk the slots oldest first; stop at the first one that cannot issue and
  // withdraw a branch whose delay slot fails to issue alongside it
  always_comb begin
    used    = '0;
    avail   = '0;
    stop    = 1'b0;
    pend_br = 1'b0;
    found   = 1'b0;
    ok      = 1'b0;
    pick    = '0;
    br_slot = '0;
    cls     = 2'd0;
    cnt_d   = '0;
    slot_iss = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      slot_unit[i] = '0;
    end
    for (int i = 0; i < ISSUE_W; i++) begin
      found = 1'b0;
      pick  = '0;
      avail = unit_free & ~used;
      cls   = bus.slot_class_i[2*i +: 2];
      case (cls)
        CLS_ALU: begin
          // ALUs sit below the MULs, so lowest-first covers the overflow
          for (int u = 0; u < N_ALU + N_MUL; u++) begin
            pick  = (!found && avail[u]) ? UW'(u) : pick;
            found = found | avail[u];
          end
        end
        CLS_MUL: begin
          for (int u = N_ALU; u < N_ALU + N_MUL; u++) begin
            pick  = (!found && avail[u]) ? UW'(u) : pick;
            found = found | avail[u];
          end
        end
        CLS_LS: begin
          found = avail[LS_IDX];
          pick  = UW'(LS_IDX);
        end
        CLS_BR: begin
          found = avail[BR_IDX];
          pick  = UW'(BR_IDX);
        end
        default: begin
          found = 1'b0;
          pick  = '0;
        end
      endcase
      ok = !stop && !flush_i && bus.slot_valid_i[i] &&
           bus.slot_ops_ready_i[i] && found;
      if (ok) begin
        used[pick]   = 1'b1;
        slot_unit[i] = pick;
        slot_iss[i]  = 1'b1;
        if (cls == CLS_BR) begin
          // Branch waits for its delay slot before it is counted
          pend_br = 1'b1;
          br_slot = SW'(i);
        end else begin
          cnt_d   = cnt_d + (pend_br ? CW'(2) : CW'(1));
          pend_br = 1'b0;
        end
      end else begin
        stop              = 1'b1;
        slot_iss[br_slot] = slot_iss[br_slot] & ~pend_br;
        pend_br           = 1'b0;
      end
    end
    // Branch in the last slot never has its delay slot this cycle
    slot_iss[br_slot] = slot_iss[br_slot] & ~pend_br;
  end

  // Invert slot->unit steering into per-unit load enables and source slots
  always_comb begin
    load = '0;
    hit  = 1'b0;
    for (int u = 0; u < NU; u++) begin
      load_src[u] = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
        hit         = slot_iss[i] && (slot_unit[i] == UW'(u));
        load[u]     = load[u] | hit;
        load_src[u] = hit ? SW'(i) : load_src[u];
      end
    end
  end

  // Unit registers: load on issue, clear on accepted handshake, else hold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      u_valid_q <= '0;
      u_rob_q   <= '0;
      u_a_q     <= '0;
      u_b_q     <= '0;
      u_c_q     <= '0;
      u_inst_q  <= '0;
    end else if (flush_i) begin
      u_valid_q <= '0;
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (load[u]) begin
          u_valid_q[u]               <= 1'b1;
          u_rob_q[u*ROB_W +: ROB_W]  <= bus.slot_rob_i[load_src[u]*ROB_W +: ROB_W];
          u_a_q[u*DW +: DW]          <= bus.slot_a_i[load_src[u]*DW +: DW];
          u_b_q[u*DW +: DW]          <= bus.slot_b_i[load_src[u]*DW +: DW];
          u_c_q[u*DW +: DW]          <= bus.slot_c_i[load_src[u]*DW +: DW];
          u_inst_q[u*IW +: IW]       <= bus.slot_inst_i[load_src[u]*IW +: IW];
        end else if (u_valid_q[u] && bus.u_ready_i[u]) begin
          u_valid_q[u] <= 1'b0;
        end else begin
          u_valid_q[u] <= u_valid_q[u];
        end
      end
    end
  end

  assign bus.iq_consumed_o = cnt_d;
  assign bus.iq_enable_o   = (cnt_d != '0);
  assign bus.u_valid_o     = u_valid_q;
  assign bus.u_rob_o       = u_rob_q;
  assign bus.u_a_o         = u_a_q;
  assign bus.u_b_o         = u_b_q;
  assign bus.u_c_o         = u_c_q;
  assign bus.u_inst_o      = u_inst_q;
endmodule

// File: tb/tb_iss_inorder_n.sv
// Scoreboard bench for iss_inorder_n: directed slot patterns push expected
// per-cycle pop counts/unit occupancy and expected unit transactions; a
// negedge monitor pops and compares them.
module tb_iss_inorder_n;
  localparam int ISSUE_W = 4;
  localparam int N_ALU   = 2;
  localparam int N_MUL   = 1;
  localparam int ROB_W   = 4;
  localparam int DW      = 32;
  localparam int IW      = 64;
  localparam int NU      = 5;

  localparam logic [1:0] ALU = 2'd0;
  localparam logic [1:0] MUL = 2'd1;
  localparam logic [1:0] LS  = 2'd2;
  localparam logic [1:0] BR  = 2'd3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  iss_inorder_n_if #(.ISSUE_W(ISSUE_W), .N_ALU(N_ALU), .N_MUL(N_MUL),
                     .ROB_W(ROB_W), .DW(DW), .IW(IW)) bus ();

  iss_inorder_n #(.ISSUE_W(ISSUE_W), .N_ALU(N_ALU), .N_MUL(N_MUL),
                  .ROB_W(ROB_W), .DW(DW), .IW(IW)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .flush_i (flush),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0]    cons;
    logic [NU-1:0] uv;
    string         tag;
  } cyc_t;

  typedef struct {
    int          unit;
    logic [3:0]  rob;
    logic [31:0] base;
  } tx_t;

  cyc_t cyc_q[$];
  tx_t  tx_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  cyc_t mon_c;
  tx_t  mon_t;
  int   mon_k;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: per-cycle pop/occupancy checks and per-handshake payload checks
  always @(negedge clk) begin
    if (reset_n) begin
      if (cyc_q.size() > 0) begin
        mon_c = cyc_q.pop_front();
        chk({mon_c.tag, ".consumed"}, 64'(bus.iq_consumed_o), 64'(mon_c.cons));
        chk({mon_c.tag, ".enable"}, 64'(bus.iq_enable_o), 64'(mon_c.cons != 3'd0));
        chk({mon_c.tag, ".u_valid"}, 64'(bus.u_valid_o), 64'(mon_c.uv));
      end
      for (int u = 0; u < NU; u++) begin
        if (bus.u_valid_o[u] && bus.u_ready_i[u]) begin
          mon_k = -1;
          for (int j = 0; j < tx_q.size(); j++) begin
            if (mon_k < 0 && tx_q[j].unit == u) mon_k = j;
          end
          if (mon_k < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_handshake: unit %0d rob %0d, no transaction expected",
                     u, bus.u_rob_o[u*ROB_W +: ROB_W]);
          end else begin
            mon_t = tx_q[mon_k];
            tx_q.delete(mon_k);
            chk($sformatf("u%0d.rob", u), 64'(bus.u_rob_o[u*ROB_W +: ROB_W]), 64'(mon_t.rob));
            chk($sformatf("u%0d.a", u), 64'(bus.u_a_o[u*DW +: DW]), 64'(mon_t.base));
            chk($sformatf("u%0d.b", u), 64'(bus.u_b_o[u*DW +: DW]),
                64'(mon_t.base ^ 32'hFFFF0000));
            chk($sformatf("u%0d.c", u), 64'(bus.u_c_o[u*DW +: DW]), 64'(mon_t.base + 32'd7));
            chk($sformatf("u%0d.inst", u), bus.u_inst_o[u*IW +: IW], {~mon_t.base, mon_t.base});
          end
        end
      end
    end
  end

  task automatic clear_slots();
    bus.slot_valid_i     = '0;
    bus.slot_ops_ready_i = '0;
    bus.slot_class_i     = '0;
    bus.slot_rob_i       = '0;
    bus.slot_a_i         = '0;
    bus.slot_b_i         = '0;
    bus.slot_c_i         = '0;
    bus.slot_inst_i      = '0;
  endtask

  task automatic set_slot(int i, logic [1:0] cls, logic [3:0] rob,
                          logic [31:0] base, logic rdy);
    bus.slot_valid_i[i]             = 1'b1;
    bus.slot_ops_ready_i[i]         = rdy;
    bus.slot_class_i[2*i +: 2]      = cls;
    bus.slot_rob_i[ROB_W*i +: ROB_W] = rob;
    bus.slot_a_i[DW*i +: DW]        = base;
    bus.slot_b_i[DW*i +: DW]        = base ^ 32'hFFFF0000;
    bus.slot_c_i[DW*i +: DW]        = base + 32'd7;
    bus.slot_inst_i[IW*i +: IW]     = {~base, base};
  endtask

  task automatic expect_tx(int unit, logic [3:0] rob, logic [31:0] base);
    tx_t t;
    t.unit = unit;
    t.rob  = rob;
    t.base = base;
    tx_q.push_back(t);
  endtask

  // Record the expectation for the current cycle, then advance one clock
  task automatic step(logic [2:0] cons, logic [NU-1:0] uv, string tag);
    cyc_t c;
    c.cons = cons;
    c.uv   = uv;
    c.tag  = tag;
    cyc_q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_slots();
    bus.u_ready_i = 5'b11111;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    step(3'd0, 5'b00000, "reset");

    // Four ALUs: ALU0, ALU1, overflow onto MUL0, fourth stalls
    set_slot(0, ALU, 4'd1, 32'h0000_1001, 1'b1);
    set_slot(1, ALU, 4'd2, 32'h0000_1002, 1'b1);
    set_slot(2, ALU, 4'd3, 32'h0000_1003, 1'b1);
    set_slot(3, ALU, 4'd4, 32'h0000_1004, 1'b1);
    expect_tx(0, 4'd1, 32'h0000_1001);
    expect_tx(1, 4'd2, 32'h0000_1002);
    expect_tx(2, 4'd3, 32'h0000_1003);
    step(3'd3, 5'b00000, "alu4");
    clear_slots();
    step(3'd0, 5'b00111, "alu4_out");

    // LS, ALU, MUL, BR: branch in the last slot waits for its delay slot
    set_slot(0, LS,  4'd5, 32'h0000_2001, 1'b1);
    set_slot(1, ALU, 4'd6, 32'h0000_2002, 1'b1);
    set_slot(2, MUL, 4'd7, 32'h0000_2003, 1'b1);
    set_slot(3, BR,  4'd8, 32'h0000_2004, 1'b1);
    expect_tx(3, 4'd5, 32'h0000_2001);
    expect_tx(0, 4'd6, 32'h0000_2002);
    expect_tx(2, 4'd7, 32'h0000_2003);
    step(3'd3, 5'b00000, "br_last");
    clear_slots();
    set_slot(0, BR,  4'd8, 32'h0000_2004, 1'b1);
    set_slot(1, ALU, 4'd9, 32'h0000_2005, 1'b1);
    expect_tx(4, 4'd8, 32'h0000_2004);
    expect_tx(0, 4'd9, 32'h0000_2005);
    step(3'd2, 5'b01101, "br_delay");
    clear_slots();
    step(3'd0, 5'b10001, "br_delay_out");

    // Oldest not ready blocks a younger ready one
    set_slot(0, ALU, 4'd10, 32'h0000_3001, 1'b0);
    set_slot(1, ALU, 4'd11, 32'h0000_3002, 1'b1);
    step(3'd0, 5'b00000, "in_order");

    // BR followed by BR: only the leading ALU issues
    clear_slots();
    set_slot(0, ALU, 4'd12, 32'h0000_4001, 1'b1);
    set_slot(1, BR,  4'd13, 32'h0000_4002, 1'b1);
    set_slot(2, BR,  4'd14, 32'h0000_4003, 1'b1);
    expect_tx(0, 4'd12, 32'h0000_4001);
    step(3'd1, 5'b00000, "br_br");
    clear_slots();
    set_slot(0, BR, 4'd13, 32'h0000_4002, 1'b1);
    step(3'd0, 5'b00001, "br_no_delay");

    // LS backpressure: held for three cycles, reload on completing edge
    clear_slots();
    bus.u_ready_i = 5'b10111;
    set_slot(0, LS, 4'd1, 32'h0000_5001, 1'b1);
    expect_tx(3, 4'd1, 32'h0000_5001);
    step(3'd1, 5'b00000, "ls_issue");
    set_slot(0, LS, 4'd2, 32'h0000_5002, 1'b1);
    step(3'd0, 5'b01000, "ls_hold1");
    step(3'd0, 5'b01000, "ls_hold2");
    step(3'd0, 5'b01000, "ls_hold3");
    bus.u_ready_i = 5'b11111;
    expect_tx(3, 4'd2, 32'h0000_5002);
    step(3'd1, 5'b01000, "ls_reload");
    clear_slots();
    step(3'd0, 5'b01000, "ls_drain");

    // Flush with three units occupied and slots on offer
    set_slot(0, ALU, 4'd3, 32'h0000_6001, 1'b1);
    set_slot(1, ALU, 4'd4, 32'h0000_6002, 1'b1);
    set_slot(2, LS,  4'd5, 32'h0000_6003, 1'b1);
    step(3'd3, 5'b00000, "pre_flush");
    clear_slots();
    bus.u_ready_i = 5'b00000;
    set_slot(0, ALU, 4'd6, 32'h0000_6004, 1'b1);
    set_slot(1, MUL, 4'd7, 32'h0000_6005, 1'b1);
    flush = 1'b1;
    step(3'd0, 5'b01011, "flush");
    flush = 1'b0;
    clear_slots();
    bus.u_ready_i = 5'b11111;
    step(3'd0, 5'b00000, "post_flush");

    // Full-width issue: LS, ALU, BR + delay-slot ALU -> 4 popped
    set_slot(0, LS,  4'd8,  32'h0000_7001, 1'b1);
    set_slot(1, ALU, 4'd9,  32'h0000_7002, 1'b1);
    set_slot(2, BR,  4'd10, 32'h0000_7003, 1'b1);
    set_slot(3, ALU, 4'd11, 32'h0000_7004, 1'b1);
    expect_tx(3, 4'd8,  32'h0000_7001);
    expect_tx(0, 4'd9,  32'h0000_7002);
    expect_tx(4, 4'd10, 32'h0000_7003);
    expect_tx(1, 4'd11, 32'h0000_7004);
    step(3'd4, 5'b00000, "full4");
    clear_slots();
    step(3'd0, 5'b11011, "full4_out");

    // Asynchronous reset between edges drops a held instruction
    bus.u_ready_i = 5'b00000;
    set_slot(0, ALU, 4'd12, 32'h0000_8001, 1'b1);
    step(3'd1, 5'b00000, "pre_rst");
    clear_slots();
    step(3'd0, 5'b00001, "held");
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst.u_valid", 64'(bus.u_valid_o), 64'd0);
    chk("async_rst.u_a0", 64'(bus.u_a_o[0 +: DW]), 64'd0);
    #1 reset_n = 1'b1;
    bus.u_ready_i = 5'b11111;
    step(3'd0, 5'b00000, "post_rst");

    chk("leftover_tx", 64'(tx_q.size()), 64'd0);
    chk("leftover_cyc", 64'(cyc_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
